// File: rtl/wb_pipe_pkg.sv
// Shared types for the write-back pipeline stage: the stage occupancy states
// and the bit positions of the fields inside the control bundle.
package wb_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } wb_state_e;

    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_BYTE_LO   = 2;
    localparam int CTRL_BYTE_HI   = 5;
    localparam int CTRL_LINK      = 6;
    localparam int CTRL_JR        = 7;

endpackage

// File: rtl/wb_pipe_slot.sv
// One payload register of the write-back skid buffer. Clear wins over load so
// a flush always leaves the slot zeroed.
module wb_pipe_slot #(
    parameter int W = 77
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // NOTE: non-blocking assignment on every register so all flops sample
    // pre-edge values together, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/wb_pipe_stage.sv
// MEM->WB pipeline register built as a 2-entry skid buffer with a registered
// in_ready. Optional stall counter enabled by WB_PIPE_STAGE_PERF_EN.
module wb_pipe_stage
    import wb_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CTRL_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_result,
    input  logic [DATA_W-1:0] in_pc4,
    input  logic [REG_W-1:0]  in_wreg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_result,
    output logic [DATA_W-1:0] out_pc4,
    output logic [REG_W-1:0]  out_wreg
`ifdef WB_PIPE_STAGE_PERF_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    localparam int PW = CTRL_W + 2 * DATA_W + REG_W;

    wb_state_e   state, next_state;
    logic        accept, drain;
    logic        main_load, main_clr, main_from_skid;
    logic        skid_load, skid_clr;
    logic [PW-1:0] in_pay, main_d, main_q, skid_q;

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;
    assign in_pay = {in_ctrl, in_result, in_pc4, in_wreg};
    assign main_d = main_from_skid ? skid_q : in_pay;

    // NOTE: every signal written here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        next_state     = state;
        main_load      = 1'b0;
        main_clr       = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        skid_clr       = 1'b0;
        if (flush) begin
            next_state = EMPTY;
            main_clr   = 1'b1;
            skid_clr   = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        next_state = ONE;
                        main_load  = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        next_state = FULL;
                        skid_load  = 1'b1;
                    end else if (drain) begin
                        next_state = EMPTY;
                        main_clr   = 1'b1;
                    end
                end
                FULL: begin
                    if (drain) begin
                        next_state     = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                        skid_clr       = 1'b1;
                    end
                end
                default: begin
                    next_state = EMPTY;
                    main_clr   = 1'b1;
                    skid_clr   = 1'b1;
                end
            endcase
        end
    end

    // in_ready is registered from the next occupancy so it never depends
    // combinationally on out_ready; it stays low through reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            in_ready <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state != FULL);
        end
    end

    // NOTE: the payload slots are plain registers, so they are reset to zero
    // like any other state; a cleared slot is what keeps bubbles at RegWrite=0.
    wb_pipe_slot #(.W(PW)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .q     (main_q)
    );

    wb_pipe_slot #(.W(PW)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (in_pay),
        .q     (skid_q)
    );

    assign out_valid = (state != EMPTY);
    assign {out_ctrl, out_result, out_pc4, out_wreg} = out_valid ? main_q : '0;

`ifdef WB_PIPE_STAGE_PERF_EN
    // Counts stalled cycles; saturates and survives flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_pipe_stage.sv
// Self-checking bench for wb_pipe_stage: a queue-based reference model tracks
// held entries, a negedge monitor compares every output against it.
module tb_wb_pipe_stage;
    import wb_pipe_pkg::*;

    typedef struct packed {
        logic [7:0]  ctrl;
        logic [31:0] result;
        logic [31:0] pc4;
        logic [4:0]  wreg;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_ctrl = '0;
    logic [31:0] in_result = '0;
    logic [31:0] in_pc4 = '0;
    logic [4:0]  in_wreg = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [7:0]  out_ctrl;
    logic [31:0] out_result;
    logic [31:0] out_pc4;
    logic [4:0]  out_wreg;
`ifdef WB_PIPE_STAGE_PERF_EN
    logic [31:0] stall_cnt;
    int unsigned exp_stall = 0;
`endif

    int total = 0;
    int bad = 0;
    item_t sb[$];
    logic  exp_rdy = 1'b0;
    logic  seen_c = 1'b0;

    wb_pipe_stage #(.DATA_W(32), .REG_W(5), .CTRL_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_result  (in_result),
        .in_pc4     (in_pc4),
        .in_wreg    (in_wreg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_result (out_result),
        .out_pc4    (out_pc4),
        .out_wreg   (out_wreg)
`ifdef WB_PIPE_STAGE_PERF_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model + monitor: outputs are compared against the model queue,
    // then the queue is advanced by what the coming edge will do.
    always @(negedge clk) begin
        item_t exp_out;
        logic  drain_m, accept_m;
        if (rst) begin
            sb.delete();
            exp_rdy = 1'b0;
`ifdef WB_PIPE_STAGE_PERF_EN
            exp_stall = 0;
`endif
            check("rst_out_valid", 64'(out_valid), 64'd0);
            check("rst_in_ready", 64'(in_ready), 64'd0);
            check("rst_payload", 64'({out_ctrl, out_result, out_wreg}) | 64'(out_pc4), 64'd0);
        end else begin
            exp_out = (sb.size() > 0) ? sb[0] : '0;
            check("in_ready", 64'(in_ready), 64'(exp_rdy));
            check("out_valid", 64'(out_valid), 64'(sb.size() > 0));
            check("out_ctrl", 64'(out_ctrl), 64'(exp_out.ctrl));
            check("out_result", 64'(out_result), 64'(exp_out.result));
            check("out_pc4", 64'(out_pc4), 64'(exp_out.pc4));
            check("out_wreg", 64'(out_wreg), 64'(exp_out.wreg));
            if (out_valid && out_result == 32'hC) seen_c = 1'b1;
`ifdef WB_PIPE_STAGE_PERF_EN
            check("stall_cnt", 64'(stall_cnt), 64'(exp_stall));
            if (sb.size() > 0 && !out_ready) exp_stall++;
`endif
            drain_m  = (sb.size() > 0) && out_ready;
            accept_m = in_valid && exp_rdy;
            if (flush) begin
                sb.delete();
            end else begin
                if (drain_m) void'(sb.pop_front());
                if (accept_m) sb.push_back('{in_ctrl, in_result, in_pc4, in_wreg});
            end
            exp_rdy = (sb.size() < 2);
        end
    end

    task automatic drive(input logic v, input logic [7:0] c, input logic [31:0] r,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_ctrl   = c;
        in_result = r;
        in_pc4    = r + 32'd4;
        in_wreg   = r[4:0] ^ 5'h15;
        out_ready = ordy;
        flush     = fl;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready_low_before_first_edge", 64'(in_ready), 64'd0);
        @(negedge clk);
        check("ready_high_after_first_edge", 64'(in_ready), 64'd1);

        // Streaming at full rate
        drive(1, 8'h01, 32'h10, 1, 0);
        drive(1, 8'h03, 32'h20, 1, 0);
        drive(1, 8'h41, 32'h30, 1, 0);
        drive(0, 8'h00, 32'h0, 1, 0);
        drive(0, 8'h00, 32'h0, 1, 0);

        // Backpressure fills both slots
        drive(1, 8'h01, 32'hA, 0, 0);
        drive(1, 8'h01, 32'hB, 0, 0);
        drive(0, 8'h00, 32'h0, 0, 0);
        @(negedge clk);
        check("bp_full_ready", 64'(in_ready), 64'd0);
        check("bp_hold_a", 64'(out_result), 64'hA);
        drive(0, 8'h00, 32'h0, 1, 0);
        drive(0, 8'h00, 32'h0, 1, 0);
        drive(0, 8'h00, 32'h0, 1, 0);

        // Flush while FULL with 0xC presented
        drive(1, 8'h01, 32'hD, 0, 0);
        drive(1, 8'h01, 32'hE, 0, 0);
        drive(1, 8'h01, 32'hC, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0);
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_out_ctrl", 64'(out_ctrl), 64'd0);

        // Bubble keeps RegWrite low
        drive(0, 8'hFF, 32'h55, 1, 0);
        drive(0, 8'hFF, 32'h55, 1, 0);
        @(negedge clk);
        check("bubble_regwrite", 64'(out_ctrl[CTRL_REGWRITE]), 64'd0);

        // Stall 5 cycles then flush
        drive(1, 8'h01, 32'h77, 0, 0);
        repeat (5) drive(0, 8'h00, 32'h0, 0, 0);
        drive(0, 8'h00, 32'h0, 0, 1);
        drive(0, 8'h00, 32'h0, 1, 0);
`ifdef WB_PIPE_STAGE_PERF_EN
        @(negedge clk);
        check("stall_after_flush", 64'(stall_cnt), 64'(exp_stall));
`endif

        // Randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), $urandom,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0));
            if (i == 300) begin
                #2 rst = 1'b1;
                @(negedge clk);
                check("midrst_valid", 64'(out_valid), 64'd0);
                @(posedge clk);
                #1 rst = 1'b0;
            end
        end

        // Drain with a bounded wait
        drive(0, 8'h00, 32'h0, 1, 0);
        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("drain_empty", 64'(sb.size()), 64'd0);
        check("flushed_c_never_seen", 64'(seen_c), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
